lane_reorder_stream: RTL and testbench
======================================

// Module: lane_reorder_stream
// PURPOSE
// Streaming lane-order converter for the RMII/Ethernet datapath. Collects LANE_W-bit lanes
// (LSB lane first) into WORD_W-bit words, then re-emits each word's lanes reversed or in
// input order, selected per frame. Generalises the fixed dibit/byte reorderer with
// ready/valid backpressure, frame-last tracking and partial-word flush.
// Sits between the PHY-side dibit stream and the CRC/framing logic.
// PARAMETERS
// LANE_W  2  bits per lane/beat; WORD_W % LANE_W == 0 required
// WORD_W  8  bits per reorder word; LANES = WORD_W/LANE_W, LANES >= 2 required
// PORTS
// clk     in   1       system clock
// rst     in   1       synchronous active-high reset
// mode    in   1       1 = reverse lane order in word, 0 = pass-through order; sampled per frame
// axiiv   in   1       input lane valid
// axiid   in   LANE_W  input lane data
// axiil   in   1       input lane is last of frame
// axiir   out  1       input ready; beat accepted when axiiv & axiir
// axiov   out  1       output lane valid
// axiod   out  LANE_W  output lane data
// axiol   out  1       output lane is last of frame
// axior   in   1       downstream ready; beat consumed when axiov & axior
// BEHAVIOUR
// - One clock; reset is synchronous, active-high: clk / rst. Reset: axiov=0, axiol=0,
//   axiod=0, axiir=0 during reset then 1 next cycle; both buffers empty, counters 0,
//   frame-start flag set. Reset mid-frame discards all buffered lanes, no output emitted.
// - Two word buffers (ping-pong), each: data[WORD_W], n_lanes (1..LANES), last, mode.
// - Write side: accepted lane k goes to data[k*LANE_W +: LANE_W] of buffer wr_sel.
//   Word completes when k == LANES-1 or axiil=1; then full[wr_sel]<=1, n_lanes<=k+1,
//   last<=axiil, wr_sel toggles, k<=0. axiir = ~full[wr_sel] (registered state only).
// - mode sampled on the first accepted beat of a frame (after reset or after an axiil
//   beat) and held for every word of that frame; mid-frame mode changes ignored.
// - Read side: axiov = full[rd_sel]. Lane index j runs 0..n_lanes-1; mode=1 emits lane
//   n_lanes-1-j, mode=0 emits lane j. Partial (short) word reverses only its received lanes.
// - axiol=1 only on final emitted lane of a word whose last=1. On handshake of word's final
//   lane: full[rd_sel]<=0, rd_sel toggles, j<=0. Holding: axiod/axiol stable while axiov & ~axior.
// - Latency: first output lane valid the cycle after the word's completing lane is accepted.
// - Throughput: with axior=1 continuously, sustains 1 lane/cycle indefinitely (axiir stays 1).
// - Simultaneous: freeing buffer X and completing buffer Y in one cycle both take effect;
//   a write completing into the buffer being freed cannot occur (full blocks it).
// - Outputs driven from registered state only; no combinational path axiiv/axiid->axiov.
// STRUCTURE
// - Package lane_reorder_pkg: typedef enum logic {LR_PASS, LR_REVERSE} lr_mode_t;
//   function lanes(lane_w, word_w); typedef of buffer-entry struct for LANE_W/WORD_W defaults.
// - Sub-module lane_word_buf: one buffer entry (write lane, complete, read lane by index,
//   clear); instantiated twice. Top holds wr/rd selectors, counters, frame-start flag.
// TESTING (LANE_W=2, WORD_W=8)
// - mode=1, byte 0xB4 in as lanes 00,01,11,10, axiil on 4th, axior=1 -> out 10,11,01,00,
//   axiol on 4th, first out cycle after 4th in.
// - mode=0, same stimulus -> out 00,01,11,10; axiol on 4th.
// - mode=1, 6-lane frame 00,01,11,10,01,11 (last on 6th) -> 10,11,01,00 then 11,01, axiol on final.
// - axior=0 for 10 cycles while streaming 3 bytes -> axiir drops after 2 words buffered,
//   no lane lost/duplicated, axiod stable while stalled.
// - Toggle mode mid-frame -> no effect until next frame's first beat; 2 back-to-back
//   frames with modes 1 then 0 reorder independently.
// - Assert rst after 2 lanes of a word -> axiov=0 next cycle, next frame emits only new data.

Source files
------------

// File: rtl/lane_reorder_pkg.sv
// Purpose: shared types and helpers for the lane reorder stream.
//   lr_mode_t : per-frame lane ordering (pass-through or reversed)
//   lanes()   : number of lanes per word for a given lane/word width
//   lr_buf_t  : buffer-entry layout for the default 2-bit lane / 8-bit word geometry
package lane_reorder_pkg;

    typedef enum logic {
        LR_PASS    = 1'b0,
        LR_REVERSE = 1'b1
    } lr_mode_t;

    function automatic int unsigned lanes(input int unsigned lane_w, input int unsigned word_w);
        return word_w / lane_w;
    endfunction

    localparam int unsigned LR_LANE_W = 2;
    localparam int unsigned LR_WORD_W = 8;
    localparam int unsigned LR_LANES  = lanes(LR_LANE_W, LR_WORD_W);
    localparam int unsigned LR_NL_W   = $clog2(LR_LANES + 1);

    typedef struct packed {
        logic [LR_WORD_W-1:0] data;
        logic [LR_NL_W-1:0]   n_lanes;
        logic                 last;
        lr_mode_t             mode;
    } lr_buf_t;

endpackage

// File: rtl/lane_reorder_stream_buf.sv
// Purpose: one reorder word buffer. Lanes are written by index, the word is
// closed with its lane count / last / mode, and lanes are read back by output
// index with the stored ordering applied.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en_i         write wr_lane_i into lane wr_idx_i
//   complete_i      close the word: lane count = wr_idx_i+1, store last_i / mode_i
//   clr_i           release the buffer after its final lane is consumed
//   rd_idx_i        output lane index j
//   full_o          buffer holds a closed word
//   last_o          stored word ends a frame
//   rd_lane_c       lane selected for output index j
//   rd_final_c      j is the final lane of the stored word
module lane_word_buf
    import lane_reorder_pkg::*;
#(
    parameter int unsigned LANE_W = 2,
    parameter int unsigned WORD_W = 8,
    localparam int unsigned LANES = lanes(LANE_W, WORD_W),
    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int unsigned NL_W  = $clog2(LANES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [LANE_W-1:0] wr_lane_i,
    input  logic              complete_i,
    input  logic              last_i,
    input  lr_mode_t          mode_i,
    input  logic              clr_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              full_o,
    output logic              last_o,
    output logic [LANE_W-1:0] rd_lane_c,
    output logic              rd_final_c
);

    logic [LANES-1:0][LANE_W-1:0] data_q, data_d;
    logic [NL_W-1:0]              n_q, n_d;
    logic                         last_q, last_d;
    logic                         full_q, full_d;
    lr_mode_t                     mode_q, mode_d;
    logic [IDX_W-1:0]             src_idx;

    // Next-state: lane write, word close, release.
    always_comb begin
        data_d = data_q;
        n_d    = n_q;
        last_d = last_q;
        full_d = full_q;
        mode_d = mode_q;
        if (wr_en_i) begin
            data_d[wr_idx_i] = wr_lane_i;
        end
        if (complete_i) begin
            full_d = 1'b1;
            n_d    = NL_W'(wr_idx_i) + NL_W'(1);
            last_d = last_i;
            mode_d = mode_i;
        end
        if (clr_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            n_q    <= '0;
            last_q <= 1'b0;
            full_q <= 1'b0;
            mode_q <= LR_PASS;
        end else begin
            data_q <= data_d;
            n_q    <= n_d;
            last_q <= last_d;
            full_q <= full_d;
            mode_q <= mode_d;
        end
    end

    // Reversal is relative to the received lane count, so short words flip only what arrived.
    always_comb begin
        if (mode_q == LR_REVERSE) begin
            src_idx = IDX_W'(n_q - NL_W'(1) - NL_W'(rd_idx_i));
        end else begin
            src_idx = rd_idx_i;
        end
    end

    assign rd_lane_c  = data_q[src_idx];
    assign rd_final_c = (NL_W'(rd_idx_i) == (n_q - NL_W'(1)));
    assign full_o     = full_q;
    assign last_o     = last_q;

endmodule

// File: rtl/lane_reorder_stream.sv
// Purpose: streaming lane-order converter. Packs LANE_W-bit lanes (LSB lane
// first) into WORD_W-bit words across two ping-pong buffers and re-emits each
// word's lanes reversed or in order, chosen on the first beat of each frame.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mode                     1 = reverse lanes within each word of the frame
//   axiiv/axiid/axiil/axiir  input lane stream (valid, data, last, ready)
//   axiov/axiod/axiol/axior  output lane stream (valid, data, last, ready)
module lane_reorder_stream
    import lane_reorder_pkg::*;
#(
    parameter int unsigned LANE_W = 2,
    parameter int unsigned WORD_W = 8,
    localparam int unsigned LANES = lanes(LANE_W, WORD_W),
    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              axiiv,
    input  logic [LANE_W-1:0] axiid,
    input  logic              axiil,
    output logic              axiir,
    output logic              axiov,
    output logic [LANE_W-1:0] axiod,
    output logic              axiol,
    input  logic              axior
);

    logic             run_q;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic             fstart_q, fstart_d;
    lr_mode_t         fmode_q, fmode_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [IDX_W-1:0] j_q, j_d;

    logic [1:0]             full_w;
    logic [1:0]             last_w;
    logic [1:0]             final_w;
    logic [1:0][LANE_W-1:0] lane_w;

    lr_mode_t word_mode;
    logic     accept;
    logic     word_done;
    logic     consume;

    // Ready is held low for the reset cycle and only reflects buffer occupancy afterwards.
    assign axiir     = run_q & ~full_w[wr_sel_q];
    assign accept    = axiiv & axiir;
    assign word_mode = fstart_q ? lr_mode_t'(mode) : fmode_q;
    assign word_done = accept & ((k_q == IDX_W'(LANES - 1)) | axiil);

    assign axiov   = full_w[rd_sel_q];
    assign axiod   = axiov ? lane_w[rd_sel_q] : '0;
    assign axiol   = axiov & final_w[rd_sel_q] & last_w[rd_sel_q];
    assign consume = axiov & axior;

    for (genvar b = 0; b < 2; b++) begin : g_buf
        lane_word_buf #(
            .LANE_W (LANE_W),
            .WORD_W (WORD_W)
        ) u_buf (
            .clk        (clk),
            .rst        (rst),
            .wr_en_i    (accept & (wr_sel_q == 1'(b))),
            .wr_idx_i   (k_q),
            .wr_lane_i  (axiid),
            .complete_i (word_done & (wr_sel_q == 1'(b))),
            .last_i     (axiil),
            .mode_i     (word_mode),
            .clr_i      (consume & final_w[b] & (rd_sel_q == 1'(b))),
            .rd_idx_i   (j_q),
            .full_o     (full_w[b]),
            .last_o     (last_w[b]),
            .rd_lane_c  (lane_w[b]),
            .rd_final_c (final_w[b])
        );
    end

    // Selector, lane counter and frame-mode tracking.
    always_comb begin
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        fstart_d = fstart_q;
        fmode_d  = fmode_q;
        k_d      = k_q;
        j_d      = j_q;
        if (accept) begin
            fmode_d  = word_mode;
            fstart_d = axiil;
            if (word_done) begin
                wr_sel_d = ~wr_sel_q;
                k_d      = '0;
            end else begin
                k_d = k_q + IDX_W'(1);
            end
        end
        if (consume) begin
            if (final_w[rd_sel_q]) begin
                rd_sel_d = ~rd_sel_q;
                j_d      = '0;
            end else begin
                j_d = j_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q    <= 1'b0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            fstart_q <= 1'b1;
            fmode_q  <= LR_PASS;
            k_q      <= '0;
            j_q      <= '0;
        end else begin
            run_q    <= 1'b1;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            fstart_q <= fstart_d;
            fmode_q  <= fmode_d;
            k_q      <= k_d;
            j_q      <= j_d;
        end
    end

endmodule

// File: tb/tb_lane_reorder_stream.sv
// Bench for lane_reorder_stream (LANE_W=2, WORD_W=8): directed frames with
// known expected lane sequences, then random frames and random backpressure
// checked against a frame/word-level reference model.
module tb_lane_reorder_stream;

    localparam int unsigned LANE_W = 2;
    localparam int unsigned WORD_W = 8;
    localparam int          LANES  = WORD_W / LANE_W;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic              mode  = 1'b0;
    logic              axiiv = 1'b0;
    logic [LANE_W-1:0] axiid = '0;
    logic              axiil = 1'b0;
    logic              axior = 1'b0;
    logic              axiir;
    logic              axiov;
    logic [LANE_W-1:0] axiod;
    logic              axiol;

    typedef struct {
        logic [LANE_W-1:0] d;
        logic              l;
    } exp_t;

    exp_t              exp_q[$];
    logic [LANE_W-1:0] m_word[$];
    logic              m_fstart = 1'b1;
    logic              m_mode   = 1'b0;
    logic [LANE_W-1:0] out_log[$];
    logic              last_log[$];
    logic              hold_v = 1'b0;
    logic [LANE_W-1:0] hold_d;
    logic              hold_l;
    logic              rand_done = 1'b0;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    lane_reorder_stream #(
        .LANE_W (LANE_W),
        .WORD_W (WORD_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .mode  (mode),
        .axiiv (axiiv),
        .axiid (axiid),
        .axiil (axiil),
        .axiir (axiir),
        .axiov (axiov),
        .axiod (axiod),
        .axiol (axiol),
        .axior (axior)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    // Reference: gather a frame's lanes into words, then emit each word in order or reversed.
    task automatic model_accept(input logic [LANE_W-1:0] d, input logic l, input logic md);
        exp_t e;
        int   n;
        if (m_fstart) m_mode = md;
        m_fstart = l;
        m_word.push_back(d);
        if (m_word.size() == LANES || l) begin
            n = m_word.size();
            for (int i = 0; i < n; i++) begin
                e.d = m_mode ? m_word[n-1-i] : m_word[i];
                e.l = l && (i == n - 1);
                exp_q.push_back(e);
            end
            m_word.delete();
        end
    endtask

    // Monitor: sampled on the falling edge, i.e. the values the next rising edge acts on.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            m_word.delete();
            m_fstart = 1'b1;
            hold_v   = 1'b0;
        end else begin
            if (axiov) begin
                if (hold_v) begin
                    check("hold_data", 32'(axiod), 32'(hold_d));
                    check("hold_last", 32'(axiol), 32'(hold_l));
                end
                if (axior) begin
                    hold_v = 1'b0;
                    check("out_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("out_data", 32'(axiod), 32'(e.d));
                        check("out_last", 32'(axiol), 32'(e.l));
                    end
                    out_log.push_back(axiod);
                    last_log.push_back(axiol);
                end else begin
                    hold_v = 1'b1;
                    hold_d = axiod;
                    hold_l = axiol;
                end
            end else begin
                if (hold_v) check("hold_valid", 32'(axiov), 32'd1);
                hold_v = 1'b0;
            end
            if (axiiv && axiir) model_accept(axiid, axiil, mode);
        end
    end

    task automatic send_beat(input logic [LANE_W-1:0] d, input logic l);
        logic acc;
        int   guard;
        guard = 0;
        acc   = 1'b0;
        axiiv = 1'b1;
        axiid = d;
        axiil = l;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = axiir;
            @(posedge clk);
            #1;
            guard++;
        end
        check("beat_accepted", 32'(acc), 32'd1);
        axiiv = 1'b0;
        axiil = 1'b0;
    endtask

    task automatic send_frame(input logic [LANE_W-1:0] ln[$], input logic md, input logic flip);
        mode = md;
        for (int i = 0; i < ln.size(); i++) begin
            send_beat(ln[i], i == ln.size() - 1);
            if (i == 0 && flip) mode = ~md;
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || axiov) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(exp_q.size() == 0 && !axiov), 32'd1);
    endtask

    task automatic check_log(input string tag, input logic [LANE_W-1:0] wd[$], input logic wl[$]);
        check({tag, "_count"}, 32'(out_log.size()), 32'(wd.size()));
        for (int i = 0; i < wd.size() && i < out_log.size(); i++) begin
            check({tag, "_lane"}, 32'(out_log[i]), 32'(wd[i]));
            check({tag, "_last"}, 32'(last_log[i]), 32'(wl[i]));
        end
        out_log.delete();
        last_log.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [LANE_W-1:0] fr[$];
        logic [LANE_W-1:0] wd[$];
        logic              wl[$];
        int                n;

        // Reset state
        axior = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_axiov", 32'(axiov), 32'd0);
        check("rst_axiir", 32'(axiir), 32'd0);
        check("rst_axiol", 32'(axiol), 32'd0);
        check("rst_axiod", 32'(axiod), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_axiir", 32'(axiir), 32'd1);
        check("post_rst_axiov", 32'(axiov), 32'd0);
        @(posedge clk);
        #1;

        // 0xB4 reversed, with first-output latency
        out_log.delete();
        last_log.delete();
        fr = {2'b00, 2'b01, 2'b11, 2'b10};
        send_frame(fr, 1'b1, 1'b0);
        check("latency_valid", 32'(axiov), 32'd1);
        wait_drain("drain_rev");
        wd = {2'b10, 2'b11, 2'b01, 2'b00};
        wl = {1'b0, 1'b0, 1'b0, 1'b1};
        check_log("rev_b4", wd, wl);

        // 0xB4 pass-through
        send_frame(fr, 1'b0, 1'b0);
        wait_drain("drain_pass");
        wd = {2'b00, 2'b01, 2'b11, 2'b10};
        check_log("pass_b4", wd, wl);

        // 6-lane frame: full word then a short word
        fr = {2'b00, 2'b01, 2'b11, 2'b10, 2'b01, 2'b11};
        send_frame(fr, 1'b1, 1'b0);
        wait_drain("drain_short");
        wd = {2'b10, 2'b11, 2'b01, 2'b00, 2'b11, 2'b01};
        wl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        check_log("rev_short", wd, wl);

        // Backpressure: 3 bytes while downstream stalls for 10 cycles
        axior = 1'b0;
        fr.delete();
        for (int i = 0; i < 12; i++) fr.push_back(LANE_W'($urandom_range(0, 3)));
        fork
            send_frame(fr, 1'b1, 1'b0);
            begin
                repeat (10) @(posedge clk);
                @(negedge clk);
                check("stall_axiir_low", 32'(axiir), 32'd0);
                check("stall_axiov_high", 32'(axiov), 32'd1);
                @(posedge clk);
                #1;
                axior = 1'b1;
            end
        join
        wait_drain("drain_stall");
        check("stall_lane_count", 32'(out_log.size()), 32'd12);
        out_log.delete();
        last_log.delete();

        // Mid-frame mode toggle ignored; back-to-back frames with modes 1 then 0
        fr = {2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
        send_frame(fr, 1'b1, 1'b1);
        fr = {2'b11, 2'b10, 2'b01, 2'b00};
        send_frame(fr, 1'b0, 1'b0);
        wait_drain("drain_toggle");
        wd = {2'b11, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00};
        wl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        check_log("toggle", wd, wl);

        // Reset after 2 lanes of a word discards them
        mode = 1'b1;
        send_beat(2'b11, 1'b0);
        send_beat(2'b10, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_axiov", 32'(axiov), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_log.delete();
        last_log.delete();
        fr = {2'b01, 2'b01, 2'b00, 2'b00};
        send_frame(fr, 1'b0, 1'b0);
        wait_drain("drain_midrst");
        wd = {2'b01, 2'b01, 2'b00, 2'b00};
        wl = {1'b0, 1'b0, 1'b0, 1'b1};
        check_log("midrst", wd, wl);

        // Random frames, modes, mid-frame toggles and backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 30; f++) begin
                    fr.delete();
                    n = $urandom_range(1, 11);
                    for (int i = 0; i < n; i++) fr.push_back(LANE_W'($urandom_range(0, 3)));
                    send_frame(fr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    axior = ($urandom_range(0, 3) != 0);
                end
            end
        join
        axior = 1'b1;
        wait_drain("drain_random");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
